pipe_stage_reg: RTL

- Parametrised successor to the fixed-field inter-stage pipeline registers: one generic stage register with a valid/ready handshake and a 2-entry skid buffer.
- Separates a control field, cleared on flush/bubble, from a data field, held or cleared per parameter.
- Instantiated between ID/EXE, EXE/MEM and MEM/WB; lets hazard/stall logic backpressure without combinational ready paths across stages.

---
 rtl/pipe_stage_reg.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register with a valid/ready handshake
// and a 2-entry skid buffer (main + skid). All outputs come straight from flops, so
// there is no combinational path from out_ready to in_ready.
//
// Optional feature macro: PIPE_STAGE_REG_STATS_EN (adds stall/flush counters).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   flush      synchronous flush, drops held and incoming entries
//   in_valid   upstream entry valid
//   in_ready   stage can accept (registered, low only when both entries are held)
//   in_ctrl    upstream control field (cleared on reset/flush/bubble)
//   in_data    upstream data field
//   out_valid  main entry valid
//   out_ready  downstream accepts
//   out_ctrl   main control field, 0 whenever out_valid is 0
//   out_data   main data field
//   occupancy  entries held: 0, 1 or 2
//   stat_clr   (stats only) synchronous counter clear
//   stall_cnt  (stats only) saturating count of out_valid & !out_ready cycles
//   flush_cnt  (stats only) saturating count of flushes that discarded entries

module pipe_stage_reg #(
  parameter int unsigned CTRL_W     = 8,
  parameter int unsigned DATA_W     = 128,
  parameter bit          CLEAR_DATA = 1'b0
`ifdef PIPE_STAGE_REG_STATS_EN
  ,
  parameter int unsigned STAT_W     = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
`ifdef PIPE_STAGE_REG_STATS_EN
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] flush_cnt,
`endif
  output logic [1:0]        occupancy
);

  // The state encoding doubles as the occupancy output.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic in_fire, out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State and storage registers; data is zeroed on reset regardless of CLEAR_DATA.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StEmpty;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: if (in_fire) state_d = StOne;
        StOne: begin
          if (in_fire && !out_fire) begin
            state_d = StFull;
          end else if (!in_fire && out_fire) begin
            state_d = StEmpty;
          end
        end
        StFull:  if (out_fire) state_d = StOne;
        default: state_d = StEmpty;
      endcase
    end
  end

  // Storage next-state: loads happen only on in_fire, so X on an idle input
  // bus never reaches the registers.
  always_comb begin
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      if (CLEAR_DATA) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (in_fire) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (out_fire) begin
            // Bubble: control cleared, data left in place.
            main_ctrl_d = '0;
          end
        end
        StFull: begin
          if (out_fire) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
          end
        end
        default: begin
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end
  end

  // Outputs, all decoded from flops.
  always_comb begin
    out_valid = (state_q != StEmpty);
    in_ready  = (state_q != StFull);
    occupancy = state_q;
    out_ctrl  = main_ctrl_q;
    out_data  = main_data_q;
  end

`ifdef PIPE_STAGE_REG_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (stat_clr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (out_valid && !out_ready && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (flush && (state_q != StEmpty) && !(&flush_cnt_q)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
